// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core with valid/ack handshakes to separate instruction and data memories.
// The core halts on EBREAK, on any unsupported encoding, or on a register index beyond NUM_REGS.
module riscv_multicycle_core #(
   parameter int          NUM_REGS = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              retire,
   output logic              halted,
   output logic              zero_flag,
   output logic [31:0]       alu_result
);

   // state  | meaning
   // FETCH  | imem_req high at pc, wait for imem_ack, capture ir
   // DECODE | read rs1/rs2 into operand registers, screen legality
   // EXEC   | register ALU result; branches resolve and retire here
   // MEM    | dmem_req high until dmem_ack; stores retire here
   // WB     | write rd (not x0), advance pc, retire
   // HALT   | absorbing until reset
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam int          RI_W      = (NUM_REGS == 16) ? 4 : 5;
   localparam logic [31:0] EBREAK    = 32'h0010_0073;
   localparam logic [6:0]  OP_R      = 7'b0110011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   state_t      state, state_next;
   logic        run;
   logic [31:0] pc, ir, op_a, op_b, mdr;
   logic [31:0] regs [NUM_REGS];

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        is_r, is_addi, is_lw, is_sw, is_br, is_ebreak;
   logic        r_ok, legal, bad_idx, to_halt, br_taken;
   logic [31:0] imm_i, imm_s, imm_b, alu_b, alu, rs1_val, rs2_val;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign f7     = ir[31:25];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   assign is_r      = (opcode == OP_R);
   assign is_addi   = (opcode == OP_IMM);
   assign is_lw     = (opcode == OP_LOAD);
   assign is_sw     = (opcode == OP_STORE);
   assign is_br     = (opcode == OP_BRANCH);
   assign is_ebreak = (ir == EBREAK);

   assign r_ok = ((f7 == 7'b0000000) &&
                  (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100 || f3 == 3'b010)) ||
                 ((f7 == 7'b0100000) && (f3 == 3'b000));

   assign legal = (is_r && r_ok) ||
                  (is_addi && f3 == 3'b000) ||
                  (is_lw && f3 == 3'b010) ||
                  (is_sw && f3 == 3'b010) ||
                  (is_br && (f3 == 3'b000 || f3 == 3'b001));

   // Only the index fields an instruction format actually uses are screened.
   function automatic logic idx_bad(input logic [4:0] idx);
      return (NUM_REGS == 16) && idx[4];
   endfunction

   assign bad_idx = ((is_r || is_addi || is_lw || is_sw || is_br) && idx_bad(rs1)) ||
                    ((is_r || is_sw || is_br) && idx_bad(rs2)) ||
                    ((is_r || is_addi || is_lw) && idx_bad(rd));

   assign to_halt = !legal || is_ebreak || bad_idx;

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1[RI_W-1:0]];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2[RI_W-1:0]];

   assign alu_b    = is_r ? op_b : (is_sw ? imm_s : imm_i);
   assign br_taken = (op_a == op_b) ^ f3[0];

   always_comb begin
      alu = op_a + alu_b;
      if (is_br) begin
         alu = op_a - op_b;
      end else if (is_r) begin
         case (f3)
            3'b000:  alu = f7[5] ? (op_a - op_b) : (op_a + op_b);
            3'b111:  alu = op_a & op_b;
            3'b110:  alu = op_a | op_b;
            3'b100:  alu = op_a ^ op_b;
            3'b010:  alu = {31'd0, ($signed(op_a) < $signed(op_b))};
            default: alu = op_a + op_b;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         run   <= 1'b0;
      end else begin
         state <= state_next;
         run   <= 1'b1;
      end
   end

   // run keeps every request low until the first edge after reset releases.
   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      retire     = 1'b0;
      halted     = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = run;
            if (run && imem_ack) state_next = S_DECODE;
         end
         S_DECODE: state_next = to_halt ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (is_br) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end else if (is_lw || is_sw) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (dmem_ack) begin
               retire     = is_sw;
               state_next = is_sw ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc         <= RESET_PC;
         ir         <= '0;
         op_a       <= '0;
         op_b       <= '0;
         mdr        <= '0;
         alu_result <= '0;
         zero_flag  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: if (run && imem_ack) ir <= imem_rdata;
            S_DECODE: begin
               op_a <= rs1_val;
               op_b <= rs2_val;
            end
            S_EXEC: begin
               alu_result <= alu;
               zero_flag  <= (alu == 32'd0);
               if (is_br) pc <= br_taken ? (pc + imm_b) : (pc + 32'd4);
            end
            S_MEM: begin
               if (dmem_ack) begin
                  if (is_sw) pc  <= pc + 32'd4;
                  else       mdr <= dmem_rdata;
               end
            end
            S_WB: begin
               if (rd != 5'd0) regs[rd[RI_W-1:0]] <= is_lw ? mdr : alu_result;
               pc <= pc + 32'd4;
            end
            default: ;
         endcase
      end
   end

   assign imem_addr  = pc[ADDR_W-1:0];
   assign dmem_addr  = alu_result[ADDR_W-1:0];
   assign dmem_wdata = op_b;

endmodule
